// File: rtl/req_ack_scheduler.sv
// req_ack_scheduler
//   Round-robin scheduler sharing one fixed-latency response resource among
//   NUM_REQ requesters. At most one grant per cycle; every grant is answered
//   by an ack exactly LATENCY posedges later. Tracks which requesters have a
//   grant in flight and flags requests withdrawn before being granted.
//
// Ports
//   i_clk          system clock, posedge active
//   i_rst          asynchronous reset, active high
//   i_en           1 = new grants allowed; in-flight acks always drain
//   i_req          level requests, held until the grant is seen
//   o_gnt/_id      one-hot grant pulse and its index
//   o_ack/_id      one-hot ack pulse and its index
//   o_busy         requester has a grant in flight
//   o_outstanding  popcount of o_busy
//   o_proto_err    1-cycle pulse: a waiting request was withdrawn
//   o_err_id       lowest withdrawn index (valid with o_proto_err)
module req_ack_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic [NUM_REQ-1:0]           i_req,
    output logic [NUM_REQ-1:0]           o_gnt,
    output logic [$clog2(NUM_REQ)-1:0]   o_gnt_id,
    output logic [NUM_REQ-1:0]           o_ack,
    output logic [$clog2(NUM_REQ)-1:0]   o_ack_id,
    output logic [NUM_REQ-1:0]           o_busy,
    output logic [$clog2(NUM_REQ+1)-1:0] o_outstanding,
    output logic                         o_proto_err,
    output logic [$clog2(NUM_REQ)-1:0]   o_err_id
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int OW = $clog2(NUM_REQ+1);
    localparam int SW = IW + 1;   // room for ptr+k before wrapping

    logic [IW-1:0]              r_ptr;
    logic [NUM_REQ-1:0]         r_busy;
    logic [NUM_REQ-1:0]         r_wait;
    // Stage 0 holds the grant launched at the last edge; the ack is built
    // from the last stage, so it lands exactly LATENCY edges after the grant.
    logic [LATENCY-1:0]         r_pv;
    logic [LATENCY-1:0][IW-1:0] r_pid;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [NUM_REQ-1:0] w_ack_oh;
    logic [NUM_REQ-1:0] w_err;
    logic               w_any;
    logic               w_eany;
    logic [IW-1:0]      w_win;
    logic [IW-1:0]      w_ptr_nxt;
    logic [IW-1:0]      w_eid;
    logic [SW-1:0]      w_idx;
    logic [OW-1:0]      w_cnt;

    // Round-robin search starting at r_ptr. Busy requesters are excluded
    // using the registered busy, so a requester acked at this edge cannot
    // also be regranted at this edge.
    always_comb begin
        w_elig = i_en ? (i_req & ~r_busy) : '0;
        w_any  = 1'b0;
        w_win  = '0;
        w_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + SW'(k);
            if (w_idx >= SW'(NUM_REQ))
                w_idx = w_idx - SW'(NUM_REQ);
            if (!w_any && w_elig[w_idx[IW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_idx[IW-1:0];
            end
        end
    end

    assign w_gnt_oh  = w_any ? (NUM_REQ'(1) << w_win) : '0;
    assign w_ptr_nxt = (w_win == IW'(NUM_REQ-1)) ? '0 : w_win + 1'b1;
    assign w_ack_oh  = r_pv[LATENCY-1] ? (NUM_REQ'(1) << r_pid[LATENCY-1]) : '0;

    // Withdrawal check: lowest index wins.
    assign w_err  = r_wait & ~i_req;
    assign w_eany = |w_err;
    always_comb begin
        w_eid = '0;
        for (int i = NUM_REQ-1; i >= 0; i--)
            if (w_err[i]) w_eid = IW'(i);
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_cnt = w_cnt + OW'(r_busy[i]);
    end

    assign o_busy        = r_busy;
    assign o_outstanding = w_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr       <= '0;
            r_busy      <= '0;
            r_wait      <= '0;
            r_pv        <= '0;
            r_pid       <= '0;
            o_gnt       <= '0;
            o_gnt_id    <= '0;
            o_ack       <= '0;
            o_ack_id    <= '0;
            o_proto_err <= 1'b0;
            o_err_id    <= '0;
        end else begin
            o_gnt    <= w_gnt_oh;
            o_gnt_id <= w_win;
            if (w_any)
                r_ptr <= w_ptr_nxt;

            r_pv[0]  <= w_any;
            r_pid[0] <= w_win;
            for (int j = 1; j < LATENCY; j++) begin
                r_pv[j]  <= r_pv[j-1];
                r_pid[j] <= r_pid[j-1];
            end

            o_ack    <= w_ack_oh;
            o_ack_id <= r_pv[LATENCY-1] ? r_pid[LATENCY-1] : '0;

            // Ack and grant never hit the same index at one edge.
            r_busy <= (r_busy & ~w_ack_oh) | w_gnt_oh;

            r_wait      <= i_req & ~w_gnt_oh;
            o_proto_err <= w_eany;
            o_err_id    <= w_eid;
        end
    end
endmodule

// File: tb/tb_req_ack_scheduler.sv
module tb_req_ack_scheduler;
    localparam int N   = 4;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt, ack, busy;
    logic [1:0] gnt_id, ack_id, err_id;
    logic [2:0] outst;
    logic       perr;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    req_ack_scheduler #(.NUM_REQ(N), .LATENCY(LAT)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req),
        .o_gnt(gnt), .o_gnt_id(gnt_id), .o_ack(ack), .o_ack_id(ack_id),
        .o_busy(busy), .o_outstanding(outst),
        .o_proto_err(perr), .o_err_id(err_id)
    );

    typedef struct {
        logic       r;
        logic       e;
        logic [3:0] q;
        logic [3:0] g;
        logic [3:0] a;
        logic [3:0] b;
        int         o;
        logic       p;
        int         ee;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [1:0] oh2id(input logic [3:0] v);
        logic [1:0] id;
        id = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (v[i]) id = 2'(i);
        return id;
    endfunction

    task automatic add(input logic r, input logic e, input logic [3:0] q,
                       input logic [3:0] g, input logic [3:0] a, input logic [3:0] b,
                       input int o, input logic p, input int ee);
        vec_t v;
        v.r = r; v.e = e; v.q = q; v.g = g; v.a = a; v.b = b;
        v.o = o; v.p = p; v.ee = ee;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [3:0] eg, input logic [3:0] ea,
                         input logic [3:0] eb, input int eo, input logic ep, input int ee);
        logic [21:0] want, got;
        want = {eg, oh2id(eg), ea, oh2id(ea), eb, 3'(eo), ep, 2'(ee)};
        got  = {gnt, gnt_id, ack, ack_id, busy, outst, perr, err_id};
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got gnt=%b/%0d ack=%b/%0d busy=%b out=%0d perr=%b eid=%0d ; want gnt=%b ack=%b busy=%b out=%0d perr=%b eid=%0d",
                     nm, $time, gnt, gnt_id, ack, ack_id, busy, outst, perr, err_id,
                     eg, ea, eb, eo, ep, ee);
        end
    endtask

    // Drive inputs just after a negedge, run one posedge, return at the next negedge.
    task automatic step(input logic r, input logic e, input logic [3:0] q);
        rst = r; en = e; req = q;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: each requester carries the edge number at which its
    // ack is due; busy means that edge has not yet passed.
    int         due[N];
    int         mptr;
    int         mn;
    logic [3:0] mwait;

    task automatic model_reset();
        for (int i = 0; i < N; i++) due[i] = -1;
        mptr = 0; mn = 0; mwait = 4'b0000;
    endtask

    task automatic model_edge(input logic e, input logic [3:0] q,
                              output logic [3:0] g, output logic [3:0] a, output logic [3:0] b,
                              output int o, output logic p, output int ee);
        logic [3:0] bold, elig;
        int win;
        mn++;
        g = 4'b0; a = 4'b0; b = 4'b0; o = 0; p = 1'b0; ee = 0; win = -1;
        bold = 4'b0;
        for (int i = 0; i < N; i++) begin
            bold[i] = (due[i] >= mn);
            a[i]    = (due[i] == mn);
        end
        elig = e ? (q & ~bold) : 4'b0;
        for (int k = 0; k < N; k++)
            if (win < 0 && elig[(mptr + k) % N]) win = (mptr + k) % N;
        if (win >= 0) begin
            g[win]   = 1'b1;
            due[win] = mn + LAT;
            mptr     = (win + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            b[i] = (due[i] > mn);
            o += int'(b[i]);
        end
        for (int i = N-1; i >= 0; i--)
            if (mwait[i] && !q[i]) begin p = 1'b1; ee = i; end
        mwait = q & ~g;
    endtask

    initial begin
        logic [3:0] mg, ma, mb, cur;
        logic       mp, me;
        int         mo, mee;

        // rst, en, req  |  gnt, ack, busy, outstanding, proto_err, err_id
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        // single request, latency and busy window
        add(0, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0);
        add(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0);
        add(0, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        // two requesters held: period 3, no regrant on the ack edge
        add(0, 1, 4'b0011, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0);
        add(0, 1, 4'b0011, 4'b0010, 4'b0000, 4'b0011, 2, 0, 0);
        add(0, 1, 4'b0011, 4'b0000, 4'b0001, 4'b0010, 1, 0, 0);
        add(0, 1, 4'b0011, 4'b0001, 4'b0010, 4'b0001, 1, 0, 0);
        add(0, 1, 4'b0011, 4'b0010, 4'b0000, 4'b0011, 2, 0, 0);
        add(0, 1, 4'b0011, 4'b0000, 4'b0001, 4'b0010, 1, 0, 0);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        // all four, requesters drop once granted
        add(0, 1, 4'b1111, 4'b0001, 4'b0000, 4'b0001, 1, 0, 0);
        add(0, 1, 4'b1110, 4'b0010, 4'b0000, 4'b0011, 2, 0, 0);
        add(0, 1, 4'b1100, 4'b0100, 4'b0001, 4'b0110, 2, 0, 0);
        add(0, 1, 4'b1000, 4'b1000, 4'b0010, 4'b1100, 2, 0, 0);
        add(0, 1, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 1, 0, 0);
        add(0, 1, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 0, 0, 0);
        add(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        // pointer wrap 3 -> 0, then withdrawals while en=0
        add(0, 1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1, 0, 0);
        add(0, 1, 4'b1001, 4'b1000, 4'b0000, 4'b1100, 2, 0, 0);
        add(0, 1, 4'b0001, 4'b0001, 4'b0100, 4'b1001, 2, 0, 0);
        add(0, 0, 4'b0100, 4'b0000, 4'b1000, 4'b0001, 1, 0, 0);
        add(0, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 1, 2);
        add(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 0, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1);

        @(negedge clk);
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].e, tbl[i].q);
            check($sformatf("tbl%0d", i), tbl[i].g, tbl[i].a, tbl[i].b, tbl[i].o, tbl[i].p, tbl[i].ee);
        end

        // en=0 blocks new grants but the in-flight ack still drains
        step(1, 0, 4'b0000); check("t5_rst", 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        step(0, 1, 4'b0001); check("t5_c1", 4'b0001, 4'b0000, 4'b0001, 1, 0, 0);
        step(0, 0, 4'b0110); check("t5_c2", 4'b0000, 4'b0000, 4'b0001, 1, 0, 0);
        step(0, 0, 4'b0110); check("t5_c3", 4'b0000, 4'b0001, 4'b0000, 0, 0, 0);
        step(0, 0, 4'b0110); check("t5_c4", 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        step(0, 0, 4'b0110); check("t5_c5", 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        step(0, 1, 4'b0110); check("t5_c6", 4'b0010, 4'b0000, 4'b0010, 1, 0, 0);

        // async reset with two grants in flight
        step(1, 0, 4'b0000); check("t6_rst", 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        step(0, 1, 4'b0011); check("t6_c1", 4'b0001, 4'b0000, 4'b0001, 1, 0, 0);
        step(0, 1, 4'b0010); check("t6_c2", 4'b0010, 4'b0000, 4'b0011, 2, 0, 0);
        req = 4'b0000;
        #1 rst = 1'b1;
        #1 check("t6_async", 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 4'b0000);
            check($sformatf("t6_noack%0d", i), 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        end
        step(0, 1, 4'b1010); check("t6_ptr0", 4'b0010, 4'b0000, 4'b0010, 1, 0, 0);

        // randomized traffic against the reference model
        step(1, 0, 4'b0000); check("rnd_rst", 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        model_reset();
        cur = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            cur = cur ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            me  = ($urandom_range(0, 7) != 0);
            model_edge(me, cur, mg, ma, mb, mo, mp, mee);
            step(0, me, cur);
            check($sformatf("rnd%0d", c), mg, ma, mb, mo, mp, mee);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
